// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM data-memory access with ack timeout, write-back and PC redirect (in: pipeline op, dmem ack/rdata; out: dmem req/we/addr/wdata, stall, wb, redirect, misaligned, bus_error)
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result_w,
  input  logic [31:0] mux_output_data_or_imm,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        result_or_branch_alu,
  input  logic        result_and_branch_alu,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] mux_output_pc_branch,
  input  logic [31:0] mux_output_pc_jal,
  input  logic [31:0] mux_output_pc_jalr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        misaligned_o,
  output logic        bus_error_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       accept, mem_op, aligned, taken;
  assign accept  = state == IDLE && in_valid;
  assign mem_op  = mem_read || mem_write;
  assign aligned = alu_result_w[1:0] == 2'b00;
  assign taken   = is_jalr || is_jal || result_or_branch_alu || result_and_branch_alu;
  assign stall_o = !reset && (state == WAIT || (accept && mem_op && aligned));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid_o    <= 1'b0;
      wb_data_o     <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      misaligned_o  <= 1'b0;
      bus_error_o   <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      redirect_o   <= 1'b0;
      misaligned_o <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          if (taken) begin
            redirect_o    <= 1'b1;
            redirect_pc_o <= is_jalr ? mux_output_pc_jalr : is_jal ? mux_output_pc_jal : mux_output_pc_branch;
          end
          if (mem_op && aligned) begin
            state      <= WAIT;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write && !mem_read;
            dmem_addr  <= alu_result_w;
            dmem_wdata <= mux_output_data_or_imm;
          end else begin
            wb_valid_o   <= 1'b1;
            wb_data_o    <= mem_op ? 32'h0 : alu_result_w;
            misaligned_o <= mem_op;
          end
        end
      end else if (dmem_ack) begin
        state      <= IDLE;
        dmem_req   <= 1'b0;
        dmem_we    <= 1'b0;
        wb_valid_o <= 1'b1;
        wb_data_o  <= dmem_we ? dmem_addr : dmem_rdata;
      end else if (cnt == 8'(TIMEOUT - 1)) begin
        state       <= IDLE;
        dmem_req    <= 1'b0;
        dmem_we     <= 1'b0;
        bus_error_o <= 1'b1;
        wb_valid_o  <= 1'b1;
        wb_data_o   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and randomized transaction-level checks of mem_access_unit
module tb_mem_access_unit;
  localparam int TIMEOUT = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result_w = '0;
  logic [31:0] mux_output_data_or_imm = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        result_or_branch_alu = 1'b0;
  logic        result_and_branch_alu = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [31:0] mux_output_pc_branch = '0;
  logic [31:0] mux_output_pc_jal = '0;
  logic [31:0] mux_output_pc_jalr = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_o, wb_valid_o, redirect_o, misaligned_o, bus_error_o;
  logic [31:0] wb_data_o, redirect_pc_o;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rd, wr, bor, band, jal, jalr;
    logic [31:0] alu, data, pcb, pcj, pcr;
  } op_t;
  typedef struct {
    logic [31:0] wbd;
    int reqc, stc, rdc;
    logic [31:0] rpc;
    int misc, berr;
  } exp_t;
  typedef struct {
    op_t op;
    int ack_k;
    logic [31:0] rdata;
    exp_t e;
  } vec_t;
  typedef struct {
    logic [31:0] wbd, rpc;
    int reqc, stc, rdc, misc, wbc, stable, berr;
  } obs_t;

  logic [31:0] m_rpc = '0;
  int          m_berr = 0;
  vec_t        vecs[11];

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result_w(alu_result_w),
    .mux_output_data_or_imm(mux_output_data_or_imm), .mem_read(mem_read), .mem_write(mem_write),
    .result_or_branch_alu(result_or_branch_alu), .result_and_branch_alu(result_and_branch_alu),
    .is_jal(is_jal), .is_jalr(is_jalr), .mux_output_pc_branch(mux_output_pc_branch),
    .mux_output_pc_jal(mux_output_pc_jal), .mux_output_pc_jalr(mux_output_pc_jalr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic op_t mk_op(bit rd, bit wr, bit bor, bit band, bit jal, bit jalr,
                                logic [31:0] alu, logic [31:0] data,
                                logic [31:0] pcb, logic [31:0] pcj, logic [31:0] pcr);
    op_t o;
    o.rd = rd; o.wr = wr; o.bor = bor; o.band = band; o.jal = jal; o.jalr = jalr;
    o.alu = alu; o.data = data; o.pcb = pcb; o.pcj = pcj; o.pcr = pcr;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.rd = $urandom_range(0, 2) == 0;
    o.wr = $urandom_range(0, 2) == 0;
    o.bor = $urandom_range(0, 5) == 0;
    o.band = $urandom_range(0, 5) == 0;
    o.jal = $urandom_range(0, 5) == 0;
    o.jalr = $urandom_range(0, 5) == 0;
    o.alu = $urandom;
    if ($urandom_range(0, 3) != 0) o.alu[1:0] = 2'b00;
    o.data = $urandom; o.pcb = $urandom; o.pcj = $urandom; o.pcr = $urandom;
    return o;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic drive_op(input op_t op);
    mem_read = op.rd; mem_write = op.wr;
    result_or_branch_alu = op.bor; result_and_branch_alu = op.band;
    is_jal = op.jal; is_jalr = op.jalr;
    alu_result_w = op.alu; mux_output_data_or_imm = op.data;
    mux_output_pc_branch = op.pcb; mux_output_pc_jal = op.pcj; mux_output_pc_jalr = op.pcr;
  endtask

  task automatic noise();
    in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    result_or_branch_alu = 1'($urandom); result_and_branch_alu = 1'($urandom);
    is_jal = 1'($urandom); is_jalr = 1'($urandom);
    alu_result_w = $urandom; mux_output_data_or_imm = $urandom;
    mux_output_pc_branch = $urandom; mux_output_pc_jal = $urandom; mux_output_pc_jalr = $urandom;
  endtask

  // One instruction: accept cycle, then a fixed observation window long enough to cover a timeout.
  task automatic run_op(input op_t op, input int ack_k, input logic [31:0] rd, output obs_t o);
    logic we_e;
    o = '{default: 0};
    o.stable = 1;
    we_e = op.wr & ~op.rd;
    @(negedge clk);
    drive_op(op);
    in_valid = 1'b1;
    #1 o.stc += int'(stall_o);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= TIMEOUT + 6; c++) begin
      #1;
      o.stc += int'(stall_o);
      if (wb_valid_o) begin o.wbc++; o.wbd = wb_data_o; end
      if (redirect_o) o.rdc++;
      if (misaligned_o) o.misc++;
      if (dmem_req) begin
        o.reqc++;
        if (dmem_addr !== op.alu || dmem_we !== we_e || dmem_wdata !== op.data) o.stable = 0;
        dmem_ack = (c == ack_k);
        dmem_rdata = rd;
        noise();
      end else begin
        dmem_ack = 1'($urandom);
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      in_valid = 1'b0;
    end
    #1;
    o.rpc = redirect_pc_o;
    o.berr = int'(bus_error_o);
  endtask

  task automatic check_op(input string t, input obs_t o, input exp_t e);
    chk({t, ".stall_cycles"}, o.stc, e.stc);
    chk({t, ".req_cycles"}, o.reqc, e.reqc);
    chk({t, ".wb_pulses"}, o.wbc, 1);
    chk({t, ".wb_data"}, o.wbd, e.wbd);
    chk({t, ".redirect_pulses"}, o.rdc, e.rdc);
    chk({t, ".redirect_pc"}, o.rpc, e.rpc);
    chk({t, ".misaligned_pulses"}, o.misc, e.misc);
    chk({t, ".dmem_stable"}, o.stable, 1);
    chk({t, ".bus_error"}, o.berr, e.berr);
  endtask

  // Transaction-level reference: what the whole instruction should produce.
  task automatic model(input op_t op, input int ack_k, input logic [31:0] rd, output exp_t e);
    bit mem, red;
    mem = op.rd | op.wr;
    red = op.jalr | op.jal | op.bor | op.band;
    if (red) m_rpc = op.jalr ? op.pcr : (op.jal ? op.pcj : op.pcb);
    e = '{default: 0};
    e.rdc = int'(red);
    e.rpc = m_rpc;
    if (!mem) e.wbd = op.alu;
    else if (op.alu % 4 != 0) e.misc = 1;
    else if (ack_k >= 1 && ack_k <= TIMEOUT) begin
      e.reqc = ack_k;
      e.stc = ack_k + 1;
      e.wbd = (op.wr && !op.rd) ? op.alu : rd;
    end else begin
      e.reqc = TIMEOUT;
      e.stc = TIMEOUT + 1;
      m_berr = 1;
    end
    e.berr = m_berr;
  endtask

  initial begin
    obs_t o;
    exp_t e;
    int wb, rq;
    vecs[0]  = '{mk_op(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h100,32'h0,32'h0,32'h0,32'h0), 3, 32'hCAFEF00D, '{32'hCAFEF00D,3,4,0,32'h0,0,0}};
    vecs[1]  = '{mk_op(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h20,32'h55,32'h0,32'h0,32'h0), 2, 32'hFFFFFFFF, '{32'h20,2,3,0,32'h0,0,0}};
    vecs[2]  = '{mk_op(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h102,32'h0,32'h0,32'h0,32'h0), 1, 32'h1, '{32'h0,0,0,0,32'h0,1,0}};
    vecs[3]  = '{mk_op(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h12345678,32'h0,32'h40,32'h400,32'h800), 0, 32'h0, '{32'h12345678,0,0,1,32'h800,0,0}};
    vecs[4]  = '{mk_op(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hABC,32'h0,32'h40,32'h400,32'h800), 0, 32'h0, '{32'hABC,0,0,1,32'h40,0,0}};
    vecs[5]  = '{mk_op(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h7,32'h0,32'h111,32'h222,32'h333), 0, 32'h0, '{32'h7,0,0,0,32'h40,0,0}};
    vecs[6]  = '{mk_op(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h44,32'h77,32'h0,32'h0,32'h0), 1, 32'hDEAD0001, '{32'hDEAD0001,1,2,0,32'h40,0,0}};
    vecs[7]  = '{mk_op(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h80,32'h99,32'h0,32'h0,32'h0), TIMEOUT, 32'h5, '{32'h80,4,5,0,32'h40,0,0}};
    vecs[8]  = '{mk_op(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h10,32'h0,32'h200,32'h300,32'h400), 1, 32'hAA, '{32'hAA,1,2,1,32'h200,0,0}};
    vecs[9]  = '{mk_op(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h81,32'h1,32'h0,32'h0,32'h0), 2, 32'h0, '{32'h0,0,0,0,32'h200,1,0}};
    vecs[10] = '{mk_op(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h3,32'h0,32'h10,32'h500,32'h600), 0, 32'h0, '{32'h3,0,0,1,32'h500,0,0}};

    // Reset state, with an aligned load presented to prove stall stays low under reset.
    drive_op(mk_op(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h100,32'h0,32'h0,32'h0,32'h0));
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset.stall", stall_o, 0);
    chk("reset.dmem_req", dmem_req, 0);
    chk("reset.dmem_addr", dmem_addr, 0);
    chk("reset.wb_valid", wb_valid_o, 0);
    chk("reset.wb_data", wb_data_o, 0);
    chk("reset.redirect_pc", redirect_pc_o, 0);
    chk("reset.bus_error", bus_error_o, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].ack_k, vecs[i].rdata, o);
      check_op($sformatf("vec%0d", i), o, vecs[i].e);
    end

    run_op(mk_op(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h30,32'h0,32'h0,32'h0,32'h0), 0, 32'h0, o);
    check_op("timeout", o, '{32'h0,4,5,0,32'h500,0,1});
    run_op(mk_op(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h5,32'h0,32'h0,32'h0,32'h0), 0, 32'h0, o);
    check_op("sticky", o, '{32'h5,0,0,0,32'h500,0,1});

    // Reset in the middle of a wait abandons the request silently.
    @(negedge clk);
    drive_op(mk_op(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h60,32'h0,32'h0,32'h0,32'h0));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("midwait.req_before", dmem_req, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midwait.req", dmem_req, 0);
    chk("midwait.stall", stall_o, 0);
    chk("midwait.bus_error", bus_error_o, 0);
    chk("midwait.redirect_pc", redirect_pc_o, 0);
    @(negedge clk);
    reset = 1'b0;
    wb = 0;
    rq = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 0);
      dmem_rdata = 32'h1234;
      #1;
      wb += int'(wb_valid_o);
      rq += int'(dmem_req);
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    chk("midwait.wb_pulses", wb, 0);
    chk("midwait.req_after", rq, 0);
    m_rpc = '0;
    m_berr = 0;

    for (int i = 0; i < 150; i++) begin
      op_t op;
      int k;
      logic [31:0] rd;
      op = rand_op();
      k = $urandom_range(0, TIMEOUT + 1);
      rd = $urandom;
      model(op, k, rd, e);
      run_op(op, k, rd, o);
      check_op($sformatf("rand%0d", i), o, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
